// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial two's-complement subtractor. It computes diff = a - b one bit
//   per clock, LSB first, using a full-subtractor cell and a borrow flop.
//   A start/done handshake sequences the operation: IDLE -> RUN -> DONE.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous reset, active low
//   start  in   1      request, sampled only in IDLE
//   a      in   WIDTH  minuend, captured on the accepting edge
//   b      in   WIDTH  subtrahend, captured on the accepting edge
//   busy   out  1      high while in RUN
//   done   out  1      one-cycle pulse when the result registers update
//   diff   out  WIDTH  a - b mod 2^WIDTH, held until the next done
//   bout   out  1      unsigned borrow out (a < b unsigned)
//   ovf    out  1      signed overflow of a - b
// ---------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] sa_r;
  logic [WIDTH-1:0] sb_r;
  logic [WIDTH-1:0] sr_r;
  logic [CW-1:0]    cnt_r;
  logic             borrow_r;
  logic             amsb_r;
  logic             bmsb_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] diff_r;
  logic             bout_r;
  logic             ovf_r;

  logic             d_s;
  logic             borrow_s;
  logic [WIDTH-1:0] sr_s;
  logic             last_s;
  logic             ovf_s;

  // Full-subtractor cell on the current LSBs plus the next result shift value.
  always_comb begin
    d_s      = sa_r[0] ^ sb_r[0] ^ borrow_r;
    borrow_s = (~sa_r[0] & sb_r[0]) | (~(sa_r[0] ^ sb_r[0]) & borrow_r);
    sr_s     = sr_r >> 1;
    sr_s[WIDTH-1] = d_s;
    last_s   = (state_r == ST_RUN) && (cnt_r == CNT_ZERO);
    // Overflow only when operand signs differ and the result sign departs from a.
    ovf_s    = (amsb_r ^ bmsb_r) & (sr_s[WIDTH-1] ^ amsb_r);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, serial shifting and result/flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_r     <= {WIDTH{1'b0}};
      sb_r     <= {WIDTH{1'b0}};
      sr_r     <= {WIDTH{1'b0}};
      cnt_r    <= CNT_ZERO;
      borrow_r <= 1'b0;
      amsb_r   <= 1'b0;
      bmsb_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      diff_r   <= {WIDTH{1'b0}};
      bout_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            sa_r     <= a;
            sb_r     <= b;
            borrow_r <= 1'b0;
            cnt_r    <= CNT_LAST;
            amsb_r   <= a[WIDTH-1];
            bmsb_r   <= b[WIDTH-1];
            busy_r   <= 1'b1;
          end
        end
        ST_RUN: begin
          sa_r     <= sa_r >> 1;
          sb_r     <= sb_r >> 1;
          borrow_r <= borrow_s;
          sr_r     <= sr_s;
          if (last_s) begin
            diff_r <= sr_s;
            bout_r <= borrow_s;
            ovf_r  <= ovf_s;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_DONE: begin
          done_r <= 1'b0;
        end
        default: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign diff = diff_r;
  assign bout = bout_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//   Self-checking bench for serial_subtractor at WIDTH = 1, 8 and 16.
//   Results are compared against an arithmetic reference model of a - b.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_v = 1'b0;
  logic [15:0] a_v = 16'h0000;
  logic [15:0] b_v = 16'h0000;
  int          sel = 8;

  logic        busy1, done1, bout1, ovf1;
  logic [0:0]  diff1;
  logic        busy8, done8, bout8, ovf8;
  logic [7:0]  diff8;
  logic        busy16, done16, bout16, ovf16;
  logic [15:0] diff16;

  logic        busy_o, done_o, bout_o, ovf_o;
  logic [15:0] diff_o;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .start(start_v && (sel == 1)),
    .a(a_v[0:0]), .b(b_v[0:0]),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1), .ovf(ovf1)
  );

  serial_subtractor #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .start(start_v && (sel == 8)),
    .a(a_v[7:0]), .b(b_v[7:0]),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
  );

  serial_subtractor #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .start(start_v && (sel == 16)),
    .a(a_v), .b(b_v),
    .busy(busy16), .done(done16), .diff(diff16), .bout(bout16), .ovf(ovf16)
  );

  // Observe the instance currently selected by sel.
  always_comb begin
    case (sel)
      1: begin
        busy_o = busy1; done_o = done1; diff_o = {15'h0000, diff1};
        bout_o = bout1; ovf_o = ovf1;
      end
      16: begin
        busy_o = busy16; done_o = done16; diff_o = diff16;
        bout_o = bout16; ovf_o = ovf16;
      end
      default: begin
        busy_o = busy8; done_o = done8; diff_o = {8'h00, diff8};
        bout_o = bout8; ovf_o = ovf8;
      end
    endcase
  end

  // Reference: plain modular / signed integer arithmetic on w-bit operands.
  function automatic void ref_sub(input int w, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] d, output logic bo, output logic ov);
    int mask, av, bv, sa, sb, r;
    mask = (1 << w) - 1;
    av   = int'(a) & mask;
    bv   = int'(b) & mask;
    d    = 16'((av - bv) & mask);
    bo   = (av < bv);
    sa   = (av >= (1 << (w - 1))) ? av - (1 << w) : av;
    sb   = (bv >= (1 << (w - 1))) ? bv - (1 << w) : bv;
    r    = sa - sb;
    ov   = (r < -(1 << (w - 1))) || (r > (1 << (w - 1)) - 1);
  endfunction

  // Launch one operation from IDLE and collect what the DUT reports.
  task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] d, output logic bo, output logic ov,
                        output int lat, output int bcnt, output logic pulse_ok);
    sel = w; a_v = a; b_v = b; start_v = 1'b1;
    @(posedge clk); #1;
    start_v = 1'b0;
    a_v = 16'($urandom); b_v = 16'($urandom);
    lat = 0;
    bcnt = busy_o ? 1 : 0;
    while (!done_o && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy_o) bcnt++;
    end
    d = diff_o; bo = bout_o; ov = ovf_o;
    @(posedge clk); #1;
    pulse_ok = !done_o;
  endtask

  task automatic test_reset;
    int ws[3] = '{1, 8, 16};
    #12;
    foreach (ws[i]) begin
      sel = ws[i]; #1;
      chk_cnt++;
      if ({busy_o, done_o, diff_o, bout_o, ovf_o} !== 20'h0) begin
        $display("FAIL reset_w%0d: got busy=%b done=%b diff=%h bout=%b ovf=%b, want all 0",
                 ws[i], busy_o, done_o, diff_o, bout_o, ovf_o);
      end else pass_cnt++;
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    logic [7:0] ta[5]  = '{8'h05, 8'h03, 8'h00, 8'h80, 8'h7F};
    logic [7:0] tb_[5] = '{8'h03, 8'h05, 8'h00, 8'h01, 8'hFF};
    logic [7:0] td[5]  = '{8'h02, 8'hFE, 8'h00, 8'h7F, 8'h80};
    logic [1:0] tf[5]  = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b11};
    logic [15:0] d; logic bo, ov, pk; int lat, bc;
    foreach (ta[i]) begin
      run_op(8, {8'h00, ta[i]}, {8'h00, tb_[i]}, d, bo, ov, lat, bc, pk);
      chk_cnt++;
      if ({d, bo, ov} !== {8'h00, td[i], tf[i]}) begin
        $display("FAIL directed_%0d: got diff=%h bout=%b ovf=%b, want diff=%h bout=%b ovf=%b",
                 i, d[7:0], bo, ov, td[i], tf[i][1], tf[i][0]);
      end else pass_cnt++;
      chk_cnt++;
      if (lat !== 8 || bc !== 8 || pk !== 1'b1) begin
        $display("FAIL directed_timing_%0d: got latency=%0d busy_cycles=%0d pulse_ok=%b, want 8/8/1",
                 i, lat, bc, pk);
      end else pass_cnt++;
    end
  endtask

  task automatic test_held_start;
    logic [15:0] ea[32]; logic [15:0] eb[32];
    logic [15:0] ed; logic ebo, eov;
    int dones = 0;
    sel = 8;
    foreach (ea[i]) begin
      ea[i] = 16'($urandom_range(0, 255));
      eb[i] = 16'($urandom_range(0, 255));
    end
    start_v = 1'b1;
    for (int e = 0; e < 30; e++) begin
      a_v = ea[e]; b_v = eb[e];
      @(posedge clk); #1;
      if (e == 29) start_v = 1'b0;
      chk_cnt++;
      if (done_o !== ((e % 10) == 8)) begin
        $display("FAIL held_done_e%0d: got done=%b, want %b", e, done_o, (e % 10) == 8);
      end else pass_cnt++;
      if ((e % 10) == 8) begin
        dones++;
        ref_sub(8, ea[e - 8], eb[e - 8], ed, ebo, eov);
        chk_cnt++;
        if ({diff_o, bout_o, ovf_o} !== {ed, ebo, eov}) begin
          $display("FAIL held_result_e%0d: got diff=%h bout=%b ovf=%b, want diff=%h bout=%b ovf=%b",
                   e, diff_o, bout_o, ovf_o, ed, ebo, eov);
        end else pass_cnt++;
      end
    end
    start_v = 1'b0;
    chk_cnt++;
    if (dones !== 3) begin
      $display("FAIL held_count: got %0d done pulses, want 3", dones);
    end else pass_cnt++;
  endtask

  task automatic test_reset_mid_run;
    logic [15:0] d; logic bo, ov, pk; int lat, bc;
    logic seen = 1'b0;
    sel = 8; a_v = 16'h0033; b_v = 16'h0011; start_v = 1'b1;
    @(posedge clk); #1;
    start_v = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({busy_o, done_o, diff_o, bout_o, ovf_o} !== 20'h0) begin
      $display("FAIL midrun_reset: got busy=%b done=%b diff=%h bout=%b ovf=%b, want all 0",
               busy_o, done_o, diff_o, bout_o, ovf_o);
    end else pass_cnt++;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (14) begin
      @(posedge clk); #1;
      if (done_o) seen = 1'b1;
    end
    chk_cnt++;
    if (seen !== 1'b0) begin
      $display("FAIL midrun_no_done: got done after reset, want none");
    end else pass_cnt++;
    run_op(8, 16'h0010, 16'h0001, d, bo, ov, lat, bc, pk);
    chk_cnt++;
    if ({d, bo, ov, lat} !== {16'h000F, 1'b0, 1'b0, 32'd8}) begin
      $display("FAIL midrun_recover: got diff=%h bout=%b ovf=%b latency=%0d, want 0f/0/0/8",
               d, bo, ov, lat);
    end else pass_cnt++;
  endtask

  task automatic test_random(input int w, input int n);
    logic [15:0] a, b, d, ed; logic bo, ov, pk, ebo, eov; int lat, bc;
    logic [15:0] mask;
    mask = 16'((1 << w) - 1);
    for (int i = 0; i < n; i++) begin
      if (w == 1) begin
        a = 16'(i[1]); b = 16'(i[0]);
      end else begin
        a = 16'($urandom) & mask; b = 16'($urandom) & mask;
      end
      run_op(w, a, b, d, bo, ov, lat, bc, pk);
      ref_sub(w, a, b, ed, ebo, eov);
      chk_cnt++;
      if ({d, bo, ov} !== {ed, ebo, eov}) begin
        $display("FAIL rand_w%0d_%0d: a=%h b=%h got diff=%h bout=%b ovf=%b, want diff=%h bout=%b ovf=%b",
                 w, i, a, b, d, bo, ov, ed, ebo, eov);
      end else pass_cnt++;
      chk_cnt++;
      if (lat !== w || bc !== w || pk !== 1'b1) begin
        $display("FAIL rand_timing_w%0d_%0d: got latency=%0d busy_cycles=%0d pulse_ok=%b, want %0d/%0d/1",
                 w, i, lat, bc, pk, w, w);
      end else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_held_start();
    test_reset_mid_run();
    test_random(1, 4);
    test_random(8, 100);
    test_random(16, 1000);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
